// File: rtl/riscv_pkg.sv
// Shared core constants and the commit bus bundle used by the ROB and register file.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int NREG       = 32;
   localparam int REG_ADDR_W = $clog2(NREG);
   localparam int TAG_W      = 6;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [TAG_W-1:0]      tag;
      logic [XLEN-1:0]       val;
   } commit_bus_t;

endpackage

// File: rtl/rename_regfile_rdport.sv
// One lookup port: stored value/tag/busy, optional commit bypass when
// RENAME_REGFILE_FWD_EN is defined.
module rename_regfile_rdport #(
   parameter int XLEN    = riscv_pkg::XLEN,
   parameter int NREG    = riscv_pkg::NREG,
`ifdef RENAME_REGFILE_FWD_EN
   parameter int NCOMMIT = 2,
`endif
   parameter int TAG_W   = riscv_pkg::TAG_W,
   parameter int AW      = $clog2(NREG)
) (
   input  logic [AW-1:0]    addr_i,
   input  logic [XLEN-1:0]  val_i [NREG],
   input  logic [TAG_W-1:0] tag_i [NREG],
   input  logic [NREG-1:0]  busy_i,
`ifdef RENAME_REGFILE_FWD_EN
   input  logic [NCOMMIT-1:0] c_vld_i,
   input  logic [AW-1:0]      c_rd_i  [NCOMMIT],
   input  logic [TAG_W-1:0]   c_tag_i [NCOMMIT],
   input  logic [XLEN-1:0]    c_val_i [NCOMMIT],
`endif
   output logic [XLEN-1:0]  val_o,
   output logic             busy_o,
   output logic [TAG_W-1:0] tag_o
);

   logic [XLEN-1:0]  v;
   logic             b;
   logic [TAG_W-1:0] t;

   always_comb begin
      v = val_i[addr_i];
      b = busy_i[addr_i];
      t = tag_i[addr_i];
`ifdef RENAME_REGFILE_FWD_EN
      // Later ports overwrite earlier hits, so the youngest commit wins.
      for (int p = 0; p < NCOMMIT; p++) begin
         if (c_vld_i[p] && c_rd_i[p] == addr_i && busy_i[addr_i]
             && c_tag_i[p] == tag_i[addr_i]) begin
            v = c_val_i[p];
            b = 1'b0;
         end
      end
`endif
      if (addr_i == '0) begin
         v = '0;
         b = 1'b0;
      end
      val_o  = v;
      busy_o = b;
      tag_o  = b ? t : '0;
   end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename tags, multi-port commit and flush.
// Optional commit-to-read bypass: RENAME_REGFILE_FWD_EN.
module rename_regfile #(
   parameter int XLEN    = riscv_pkg::XLEN,
   parameter int NREG    = riscv_pkg::NREG,
   parameter int TAG_W   = riscv_pkg::TAG_W,
   parameter int NCOMMIT = 2,
   parameter int NREAD   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       flush,
   input  logic [NCOMMIT-1:0]         commit_valid,
   input  logic [NCOMMIT*$clog2(NREG)-1:0] commit_rd,
   input  logic [NCOMMIT*TAG_W-1:0]   commit_tag,
   input  logic [NCOMMIT*XLEN-1:0]    commit_val,
   input  logic                       issue_valid,
   input  logic [$clog2(NREG)-1:0]    issue_rd,
   input  logic [TAG_W-1:0]           issue_tag,
   input  logic [NREAD*$clog2(NREG)-1:0] rd_addr,
   output logic [NREAD*XLEN-1:0]      rd_val,
   output logic [NREAD-1:0]           rd_busy,
   output logic [NREAD*TAG_W-1:0]     rd_tag,
   output logic [$clog2(NREG):0]      busy_count
);

   localparam int AW = $clog2(NREG);
   localparam int CW = AW + 1;

   logic [XLEN-1:0]  val_q [NREG];
   logic [XLEN-1:0]  val_d [NREG];
   logic [TAG_W-1:0] tag_q [NREG];
   logic [TAG_W-1:0] tag_d [NREG];
   logic [NREG-1:0]  busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [AW-1:0]    c_rd  [NCOMMIT];
   logic [TAG_W-1:0] c_tag [NCOMMIT];
   logic [XLEN-1:0]  c_val [NCOMMIT];

   always_comb begin
      for (int p = 0; p < NCOMMIT; p++) begin
         c_rd[p]  = commit_rd[p*AW +: AW];
         c_tag[p] = commit_tag[p*TAG_W +: TAG_W];
         c_val[p] = commit_val[p*XLEN +: XLEN];
      end
   end

   always_comb begin
      val_d  = val_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      for (int p = 0; p < NCOMMIT; p++) begin
         if (commit_valid[p] && c_rd[p] != '0) begin
            val_d[c_rd[p]] = c_val[p];
            if (busy_q[c_rd[p]] && tag_q[c_rd[p]] == c_tag[p])
               busy_d[c_rd[p]] = 1'b0;
         end
      end
      // Rename after commit so a new producer is never cleared by an old one.
      if (issue_valid && issue_rd != '0 && !flush) begin
         tag_d[issue_rd]  = issue_tag;
         busy_d[issue_rd] = 1'b1;
      end
      if (flush)
         busy_d = '0;
      cnt_d = '0;
      for (int i = 0; i < NREG; i++)
         cnt_d = cnt_d + CW'(busy_d[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         val_q  <= '{default: '0};
         tag_q  <= '{default: '0};
         busy_q <= '0;
         cnt_q  <= '0;
      end else if (rdy) begin
         val_q  <= val_d;
         tag_q  <= tag_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_count = cnt_q;

   for (genvar r = 0; r < NREAD; r++) begin : g_rd
      rename_regfile_rdport #(
         .XLEN    (XLEN),
         .NREG    (NREG),
`ifdef RENAME_REGFILE_FWD_EN
         .NCOMMIT (NCOMMIT),
`endif
         .TAG_W   (TAG_W),
         .AW      (AW)
      ) u_port (
         .addr_i  (rd_addr[r*AW +: AW]),
         .val_i   (val_q),
         .tag_i   (tag_q),
         .busy_i  (busy_q),
`ifdef RENAME_REGFILE_FWD_EN
         .c_vld_i (commit_valid),
         .c_rd_i  (c_rd),
         .c_tag_i (c_tag),
         .c_val_i (c_val),
`endif
         .val_o   (rd_val[r*XLEN +: XLEN]),
         .busy_o  (rd_busy[r]),
         .tag_o   (rd_tag[r*TAG_W +: TAG_W])
      );
   end

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: directed stimulus, negedge monitor.
module tb_rename_regfile;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int TW   = 6;
   localparam int NC   = 2;
   localparam int NR   = 2;
`ifdef RENAME_REGFILE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst, rdy, flush, issue_valid;
   logic [NC-1:0]       commit_valid;
   logic [NC*AW-1:0]    commit_rd;
   logic [NC*TW-1:0]    commit_tag;
   logic [NC*XLEN-1:0]  commit_val;
   logic [AW-1:0]       issue_rd;
   logic [TW-1:0]       issue_tag;
   logic [NR*AW-1:0]    rd_addr;
   logic [NR*XLEN-1:0]  rd_val;
   logic [NR-1:0]       rd_busy;
   logic [NR*TW-1:0]    rd_tag;
   logic [AW:0]         busy_count;

   rename_regfile dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .commit_valid(commit_valid), .commit_rd(commit_rd),
      .commit_tag(commit_tag), .commit_val(commit_val),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_tag(issue_tag), .rd_addr(rd_addr),
      .rd_val(rd_val), .rd_busy(rd_busy), .rd_tag(rd_tag),
      .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] v0; logic b0; logic [5:0] t0;
      logic [31:0] v1; logic b1; logic [5:0] t1;
      logic [5:0]  cnt;
   } exp_t;

   exp_t sb[$];
   logic chk = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always @(negedge clk) begin
      if (chk) begin
         if (sb.size() == 0) begin
            $display("FAIL scoreboard empty: got output, want expected entry");
            n_err++;
         end else begin
            exp_t e;
            bit   bad;
            e = sb.pop_front();
            n_vec++;
            bad = 0;
            if (rd_val[31:0] !== e.v0 || rd_busy[0] !== e.b0 || rd_tag[5:0] !== e.t0) begin
               $display("FAIL %s port0: got val=%h busy=%b tag=%0d want val=%h busy=%b tag=%0d",
                        e.name, rd_val[31:0], rd_busy[0], rd_tag[5:0], e.v0, e.b0, e.t0);
               bad = 1;
            end
            if (rd_val[63:32] !== e.v1 || rd_busy[1] !== e.b1 || rd_tag[11:6] !== e.t1) begin
               $display("FAIL %s port1: got val=%h busy=%b tag=%0d want val=%h busy=%b tag=%0d",
                        e.name, rd_val[63:32], rd_busy[1], rd_tag[11:6], e.v1, e.b1, e.t1);
               bad = 1;
            end
            if (busy_count !== e.cnt) begin
               $display("FAIL %s busy_count: got %0d want %0d", e.name, busy_count, e.cnt);
               bad = 1;
            end
            if (bad) n_err++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      chk          = 1'b0;
      issue_valid  = 1'b0;
      commit_valid = '0;
      flush        = 1'b0;
   endtask

   task automatic cmt(input int p, input logic [4:0] rd,
                      input logic [5:0] tg, input logic [31:0] v);
      commit_valid[p]        = 1'b1;
      commit_rd[p*AW +: AW]  = rd;
      commit_tag[p*TW +: TW] = tg;
      commit_val[p*32 +: 32] = v;
   endtask

   task automatic iss(input logic [4:0] rd, input logic [5:0] tg);
      issue_valid = 1'b1;
      issue_rd    = rd;
      issue_tag   = tg;
   endtask

   task automatic chk_rd(input string nm, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] v0, input logic b0, input logic [5:0] t0,
                         input logic [31:0] v1, input logic b1, input logic [5:0] t1,
                         input logic [5:0] cnt);
      exp_t e;
      e.name = nm;
      e.v0 = v0; e.b0 = b0; e.t0 = t0;
      e.v1 = v1; e.b1 = b1; e.t1 = t1;
      e.cnt = cnt;
      rd_addr = {a1, a0};
      sb.push_back(e);
      chk = 1'b1;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; issue_valid = 1'b0;
      commit_valid = '0; commit_rd = '0; commit_tag = '0; commit_val = '0;
      issue_rd = '0; issue_tag = '0; rd_addr = '0;
      step(); step();
      rst = 1'b0;

      chk_rd("reset", 5, 5, 0, 0, 0, 0, 0, 0, 0); step();

      iss(5, 3); step();
      chk_rd("issue_x5", 5, 0, 0, 1, 3, 0, 0, 0, 1); step();
      cmt(0, 5, 3, 32'hDEADBEEF); step();
      chk_rd("commit_x5", 5, 5, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0, 0); step();

      iss(7, 4); step();
      iss(7, 9); step();
      chk_rd("rename_x7", 7, 5, 0, 1, 9, 32'hDEADBEEF, 0, 0, 1); step();
      cmt(0, 7, 4, 32'h1); step();
      chk_rd("tag_mismatch", 7, 7, 1, 1, 9, 1, 1, 9, 1); step();

      iss(6, 2); step();
      iss(6, 10); cmt(1, 6, 2, 32'h66); step();
      chk_rd("issue_over_commit", 6, 7, 32'h66, 1, 10, 1, 1, 9, 2); step();

      cmt(0, 8, 0, 32'h11); cmt(1, 8, 0, 32'h22); step();
      chk_rd("dual_commit_x8", 8, 6, 32'h22, 0, 0, 32'h66, 1, 10, 2); step();
      cmt(0, 0, 0, 32'hAB); step();
      iss(0, 5); step();
      chk_rd("x0_hardwired", 0, 0, 0, 0, 0, 0, 0, 0, 2); step();

      rdy = 1'b0;
      iss(10, 1); cmt(0, 8, 0, 32'h99); flush = 1'b1; step();
      rdy = 1'b1;
      chk_rd("rdy_low_hold", 8, 6, 32'h22, 0, 0, 32'h66, 1, 10, 2); step();

      iss(10, 11); step();
      iss(11, 12); step();
      iss(12, 13); step();
      chk_rd("five_busy", 10, 12, 0, 1, 11, 0, 1, 13, 5); step();
      flush = 1'b1; cmt(0, 9, 0, 32'h55); iss(13, 14); step();
      chk_rd("flush", 9, 13, 32'h55, 0, 0, 0, 0, 0, 0); step();
      chk_rd("flush_tag_hidden", 7, 10, 1, 0, 0, 0, 0, 0, 0); step();

      iss(20, 1); step();
      iss(21, 2); step();
      cmt(0, 20, 1, 32'hA); cmt(1, 21, 2, 32'hB); step();
      chk_rd("two_port_clear", 20, 21, 32'hA, 0, 0, 32'hB, 0, 0, 0); step();

      iss(5, 7); step();
      cmt(0, 5, 7, 32'h1234);
      chk_rd("bypass", 5, 5,
             FWD ? 32'h1234 : 32'hDEADBEEF, FWD ? 1'b0 : 1'b1, FWD ? 6'd0 : 6'd7,
             FWD ? 32'h1234 : 32'hDEADBEEF, FWD ? 1'b0 : 1'b1, FWD ? 6'd0 : 6'd7, 1);
      step();
      chk_rd("after_bypass", 5, 5, 32'h1234, 0, 0, 32'h1234, 0, 0, 0); step();

      iss(5, 8); step();
      cmt(1, 5, 8, 32'h77); iss(5, 9);
      chk_rd("bypass_with_issue", 5, 0,
             FWD ? 32'h77 : 32'h1234, FWD ? 1'b0 : 1'b1, FWD ? 6'd0 : 6'd8,
             0, 0, 0, 1);
      step();
      chk_rd("after_bypass_issue", 5, 5, 32'h77, 1, 9, 32'h77, 1, 9, 1); step();

      rst = 1'b1; rdy = 1'b0; step();
      rst = 1'b0; rdy = 1'b1;
      chk_rd("reset_over_rdy", 5, 8, 0, 0, 0, 0, 0, 0, 0); step();

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
         n_err++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
